inst_loader: RTL

Boot-time writer for the instruction RAM write port. It accepts a byte stream from the serial receiver through a valid/ready handshake and assembles little-endian 32-bit instruction words. It drives `is_write`/`im_addr`/`im_inst` into the instruction memory and holds the core in reset while a program image is being loaded. It sits between the UART RX front end and the instruction RAM in the pipelined core top.

---
 rtl/inst_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words and writes them into the instruction RAM.
// Optional feature: define LOADER_CHECKSUM_EN to require and verify a 32-bit sum trailer after the data words.
module inst_loader #(
    parameter int             w         = 32,
    parameter logic [w-1:0]   ADDR_BASE = '0,
    parameter int             MAX_WORDS = 2057
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic         is_write,
    output logic [w-1:0] im_addr,
    output logic [w-1:0] im_inst,
    output logic         cpu_hold,
    output logic         load_done,
    output logic         load_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t      state_reg;
    logic [1:0]  byte_idx_reg;
    logic [23:0] shift_reg;
    logic [31:0] word_cnt_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_reg;
`endif

    logic        accept;
    logic        word_complete;
    logic [31:0] rx_word;

    // The three earlier bytes sit in shift_reg, so the incoming byte completes the word combinationally.
    assign accept        = rx_valid && rx_ready;
    assign word_complete = accept && (byte_idx_reg == 2'd3);
    assign rx_word       = {rx_data, shift_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            byte_idx_reg <= 2'd0;
            shift_reg    <= '0;
            word_cnt_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg      <= '0;
`endif
            rx_ready     <= 1'b0;
            is_write     <= 1'b0;
            im_addr      <= ADDR_BASE;
            im_inst      <= '0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            is_write <= 1'b0;
            if (accept) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                shift_reg    <= {rx_data, shift_reg[23:8]};
            end

            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_reg    <= S_HDR;
                        im_addr      <= ADDR_BASE;
                        byte_idx_reg <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        sum_reg      <= '0;
`endif
                        rx_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        load_done    <= 1'b0;
                        load_err     <= 1'b0;
                    end
                end

                S_HDR: begin
                    if (word_complete) begin
                        word_cnt_reg <= rx_word;
                        if (rx_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_reg <= S_CSUM;
`else
                            state_reg <= S_DONE;
                            rx_ready  <= 1'b0;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
`endif
                        end else if (rx_word > 32'(MAX_WORDS)) begin
                            state_reg <= S_ERR;
                            rx_ready  <= 1'b0;
                            load_err  <= 1'b1;
                        end else begin
                            state_reg <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (word_complete) begin
                        state_reg <= S_WRITE;
                        rx_ready  <= 1'b0;
                        is_write  <= 1'b1;
                        im_inst   <= w'(rx_word);
                    end
                end

                // The write strobe is high during this state; address and count advance as it ends.
                S_WRITE: begin
                    im_addr      <= im_addr + w'(4);
                    word_cnt_reg <= word_cnt_reg - 32'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_reg      <= sum_reg + 32'(im_inst);
`endif
                    if (word_cnt_reg == 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_reg <= S_CSUM;
                        rx_ready  <= 1'b1;
`else
                        state_reg <= S_DONE;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
`endif
                    end else begin
                        state_reg <= S_DATA;
                        rx_ready  <= 1'b1;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (word_complete) begin
                        rx_ready <= 1'b0;
                        if (rx_word == sum_reg) begin
                            state_reg <= S_DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state_reg <= S_ERR;
                            load_err  <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state_reg <= S_IDLE;
                    rx_ready  <= 1'b0;
                    cpu_hold  <= 1'b0;
                end
            endcase
        end
    end

endmodule
